// File: rtl/uart_rx_fsm_if.sv
// Signal bundle between the UART RX frame sequencer and its sampler/checkers.
// Optional error-status signals appear when UART_RX_ERR_STATUS_EN is defined.
interface uart_rx_fsm_if #(
  parameter int PRESC_W = 6
);
  logic               RX_IN;
  logic               PAR_EN;
  logic [PRESC_W-1:0] Prescale;
  logic               strt_glitch;
  logic               par_err;
  logic               stp_err;
  logic [PRESC_W-1:0] edge_cnt;
  logic [3:0]         bit_cnt;
  logic               dat_samp_en;
  logic               deser_en;
  logic               strt_chk_en;
  logic               par_chk_en;
  logic               stp_chk_en;
  logic               data_valid;
`ifdef UART_RX_ERR_STATUS_EN
  logic               frame_par_err;
  logic               frame_stp_err;

  modport master (
    input  RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
    output edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
           par_chk_en, stp_chk_en, data_valid, frame_par_err, frame_stp_err
  );
  modport slave (
    output RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
    input  edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
           par_chk_en, stp_chk_en, data_valid, frame_par_err, frame_stp_err
  );
`else
  modport master (
    input  RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
    output edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
           par_chk_en, stp_chk_en, data_valid
  );
  modport slave (
    output RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
    input  edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
           par_chk_en, stp_chk_en, data_valid
  );
`endif
endinterface

// File: rtl/uart_rx_fsm.sv
// UART RX frame sequencer: bit/edge timing, checker strobes and byte qualification.
// Define UART_RX_ERR_STATUS_EN to add the frame_par_err / frame_stp_err status pulses.
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input logic           clk,
  input logic           rst,
  uart_rx_fsm_if.master bus
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t             state_r, state_s;
  logic [PRESC_W-1:0] edge_r, edge_s, presc_r, presc_s, chk_s, last_s;
  logic [3:0]         bit_r, bit_s;
  logic               par_en_r, par_en_s, at_last_s;
  logic               deser_r, strt_r, par_r, stp_r, valid_r;
  logic               deser_s, strt_s, par_s, stp_s, valid_s;
`ifdef UART_RX_ERR_STATUS_EN
  logic               fpe_r, fse_r, fpe_s, fse_s;
`endif

  assign chk_s     = (presc_r >> 1) + PRESC_W'(2);
  assign last_s    = presc_r - PRESC_W'(1);
  assign at_last_s = (edge_r == last_s);

  // Frame configuration is only taken while no frame is in flight.
  always_comb begin
    if (state_r == IDLE || state_r == DONE) begin
      presc_s  = bus.Prescale;
      par_en_s = bus.PAR_EN;
    end else begin
      presc_s  = presc_r;
      par_en_s = par_en_r;
    end
  end

  // Next-state, counter and strobe decode; strobes are taken from the next state so they register cleanly.
  always_comb begin
    state_s = state_r;
    edge_s  = edge_r + PRESC_W'(1);
    bit_s   = bit_r;
    case (state_r)
      IDLE: begin
        edge_s = {PRESC_W{1'b0}};
        bit_s  = 4'd0;
        if (!bus.RX_IN) state_s = START;
        else            state_s = IDLE;
      end
      START: begin
        if (at_last_s) begin
          edge_s = {PRESC_W{1'b0}};
          if (bus.strt_glitch) begin
            state_s = IDLE;
            bit_s   = 4'd0;
          end else begin
            state_s = DATA;
            bit_s   = bit_r + 4'd1;
          end
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (at_last_s) begin
          edge_s = {PRESC_W{1'b0}};
          bit_s  = bit_r + 4'd1;
          if (bit_r == 4'(DATA_WIDTH)) begin
            if (par_en_r) state_s = PARITY;
            else          state_s = STOP;
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        if (at_last_s) begin
          edge_s  = {PRESC_W{1'b0}};
          bit_s   = bit_r + 4'd1;
          state_s = STOP;
        end else begin
          state_s = PARITY;
        end
      end
      STOP: begin
        if (at_last_s) begin
          edge_s  = {PRESC_W{1'b0}};
          bit_s   = bit_r + 4'd1;
          state_s = DONE;
        end else begin
          state_s = STOP;
        end
      end
      DONE: begin
        // The DONE cycle already counts as edge 0 of a back-to-back start bit.
        bit_s = 4'd0;
        if (!bus.RX_IN) begin
          state_s = START;
        end else begin
          state_s = IDLE;
          edge_s  = {PRESC_W{1'b0}};
        end
      end
      default: begin
        state_s = IDLE;
        edge_s  = {PRESC_W{1'b0}};
        bit_s   = 4'd0;
      end
    endcase

    deser_s = (state_s == DATA)   && (edge_s == chk_s);
    strt_s  = (state_s == START)  && (edge_s == chk_s);
    par_s   = (state_s == PARITY) && (edge_s == chk_s);
    stp_s   = (state_s == STOP)   && (edge_s == chk_s);
    valid_s = (state_s == DONE) && !bus.stp_err && !(par_en_r && bus.par_err);
`ifdef UART_RX_ERR_STATUS_EN
    fpe_s   = (state_s == DONE) && par_en_r && bus.par_err;
    fse_s   = (state_s == DONE) && bus.stp_err;
`endif
  end

  // State, counters, latched frame configuration and registered strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= IDLE;
      edge_r   <= {PRESC_W{1'b0}};
      bit_r    <= 4'd0;
      presc_r  <= {PRESC_W{1'b0}};
      par_en_r <= 1'b0;
      deser_r  <= 1'b0;
      strt_r   <= 1'b0;
      par_r    <= 1'b0;
      stp_r    <= 1'b0;
      valid_r  <= 1'b0;
`ifdef UART_RX_ERR_STATUS_EN
      fpe_r    <= 1'b0;
      fse_r    <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      edge_r   <= edge_s;
      bit_r    <= bit_s;
      presc_r  <= presc_s;
      par_en_r <= par_en_s;
      deser_r  <= deser_s;
      strt_r   <= strt_s;
      par_r    <= par_s;
      stp_r    <= stp_s;
      valid_r  <= valid_s;
`ifdef UART_RX_ERR_STATUS_EN
      fpe_r    <= fpe_s;
      fse_r    <= fse_s;
`endif
    end
  end

  assign bus.edge_cnt    = edge_r;
  assign bus.bit_cnt     = bit_r;
  assign bus.dat_samp_en = (state_r != IDLE);
  assign bus.deser_en    = deser_r;
  assign bus.strt_chk_en = strt_r;
  assign bus.par_chk_en  = par_r;
  assign bus.stp_chk_en  = stp_r;
  assign bus.data_valid  = valid_r;
`ifdef UART_RX_ERR_STATUS_EN
  assign bus.frame_par_err = fpe_r;
  assign bus.frame_stp_err = fse_r;
`endif
endmodule
